// File: rtl/axis_compare_pkg.sv
// Shared FSM state, "no axis" encoding and signed-magnitude helper for the axis comparator.
// Pure declarations: no latency, no flow control.
package axis_compare_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Wide enough for any practical sample width; callers sign-extend into it.
    localparam int MAG_W = 64;

    // "No axis" is a cleared valid flag; its index is always held at zero.
    localparam logic AXIS_NONE = 1'b0;

    // The most negative input maps to +2^(MAG_W-1)-range magnitude without wrapping
    // once the caller has sign-extended a narrower sample.
    function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/dominant_hysteresis.sv
// Filters dominant-axis changes: a new winner must repeat HYST_COUNT commits in a row.
// Updates on the commit strobe edge; no backpressure, one decision per strobe.
module dominant_hysteresis
    import axis_compare_pkg::*;
#(
    parameter int NAXES      = 3,
    parameter int HYST_COUNT = 3,
    parameter int IDX_W      = (NAXES > 2) ? $clog2(NAXES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             commit_i,
    input  logic             win_vld_i,
    input  logic [IDX_W-1:0] win_idx_i,
    output logic [IDX_W-1:0] dom_idx_o,
    output logic             dom_vld_o
);

    localparam int               CNT_W    = $clog2(HYST_COUNT + 1);
    localparam logic [CNT_W-1:0] HYST_LIM = CNT_W'(HYST_COUNT);

    logic             cur_vld_q,  cur_vld_d;
    logic [IDX_W-1:0] cur_idx_q,  cur_idx_d;
    logic             cand_vld_q, cand_vld_d;
    logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_eq_cur;
    logic             win_eq_cand;

    // Keep NONE at index zero so plain equality compares {valid,index} pairs.
    assign win_idx     = win_vld_i ? win_idx_i : '0;
    assign win_eq_cur  = (win_vld_i == cur_vld_q)  && (win_idx == cur_idx_q);
    assign win_eq_cand = (win_vld_i == cand_vld_q) && (win_idx == cand_idx_q);

    always_comb begin
        cur_vld_d  = cur_vld_q;
        cur_idx_d  = cur_idx_q;
        cand_vld_d = cand_vld_q;
        cand_idx_d = cand_idx_q;
        cnt_d      = cnt_q;
        if (commit_i) begin
            if (win_eq_cur) begin
                cnt_d = '0;
            end else if (win_eq_cand) begin
                if (cnt_q + 1'b1 == HYST_LIM) begin
                    cur_vld_d = cand_vld_q;
                    cur_idx_d = cand_idx_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_vld_d = win_vld_i;
                cand_idx_d = win_idx;
                cnt_d      = CNT_W'(1);
                if (HYST_COUNT == 1) begin
                    cur_vld_d = win_vld_i;
                    cur_idx_d = win_idx;
                    cnt_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_vld_q  <= AXIS_NONE;
            cur_idx_q  <= '0;
            cand_vld_q <= AXIS_NONE;
            cand_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            cur_vld_q  <= cur_vld_d;
            cur_idx_q  <= cur_idx_d;
            cand_vld_q <= cand_vld_d;
            cand_idx_q <= cand_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dom_idx_o = cur_idx_q;
    assign dom_vld_o = cur_vld_q;

endmodule

// File: rtl/axis_dominance_compare.sv
// Captures NAXES signed samples, scans one axis per cycle for sign/activity and dominant axis.
// Accept-to-RESCAN is NAXES+1 edges; new samples are ignored until the commit returns to IDLE.
module axis_dominance_compare
    import axis_compare_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NAXES      = 3,
    parameter int DEADBAND   = 4,
    parameter int HYST_COUNT = 3
) (
    input  logic                                         MCLK,
    input  logic                                         RST,
    input  logic                                         TIC,
    input  logic                                         COMPLETED,
    input  logic [NAXES*WIDTH-1:0]                       AXES,
    output logic                                         RESCAN,
    output logic [NAXES-1:0]                             SIGN,
    output logic [NAXES-1:0]                             ACTIVE,
    output logic [((NAXES > 2) ? $clog2(NAXES) : 1)-1:0] DOMINANT,
    output logic                                         DOM_VALID
);

    localparam int               IDX_W  = (NAXES > 2) ? $clog2(NAXES) : 1;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NAXES - 1);
    localparam logic [WIDTH-1:0] DB_LIM = WIDTH'(DEADBAND);

    state_e                 state_q;
    logic [NAXES*WIDTH-1:0] sample_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   best_vld_q;
    logic [IDX_W-1:0]       best_idx_q;
    logic [WIDTH-1:0]       best_mag_q;
    logic [NAXES-1:0]       pend_sign_q;
    logic [NAXES-1:0]       pend_act_q;
    logic [NAXES-1:0]       sign_q;
    logic [NAXES-1:0]       act_q;
    logic                   rescan_q;

    logic [WIDTH-1:0]       cur_val;
    logic [WIDTH-1:0]       cur_mag;
    logic                   cur_act;

    assign cur_val = sample_q[idx_q*WIDTH +: WIDTH];
    assign cur_mag = WIDTH'(magnitude({{(MAG_W-WIDTH){cur_val[WIDTH-1]}}, cur_val}));
    assign cur_act = cur_mag > DB_LIM;

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            idx_q       <= '0;
            best_vld_q  <= 1'b0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            pend_sign_q <= '0;
            pend_act_q  <= '0;
            sign_q      <= '0;
            act_q       <= '0;
            rescan_q    <= 1'b0;
        end else begin
            rescan_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (TIC && COMPLETED) begin
                        sample_q   <= AXES;
                        idx_q      <= '0;
                        best_vld_q <= 1'b0;
                        best_idx_q <= '0;
                        best_mag_q <= '0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    pend_act_q[idx_q]  <= cur_act;
                    pend_sign_q[idx_q] <= cur_act && !cur_val[WIDTH-1];
                    // Strict compare keeps the lowest index on ties.
                    if (cur_act && (cur_mag > best_mag_q)) begin
                        best_vld_q <= 1'b1;
                        best_idx_q <= idx_q;
                        best_mag_q <= cur_mag;
                    end
                    if (idx_q == LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                COMMIT: begin
                    sign_q   <= pend_sign_q;
                    act_q    <= pend_act_q;
                    rescan_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dominant_hysteresis #(
        .NAXES      (NAXES),
        .HYST_COUNT (HYST_COUNT),
        .IDX_W      (IDX_W)
    ) u_hyst (
        .clk_i     (MCLK),
        .rst_i     (RST),
        .commit_i  (state_q == COMMIT),
        .win_vld_i (best_vld_q),
        .win_idx_i (best_idx_q),
        .dom_idx_o (DOMINANT),
        .dom_vld_o (DOM_VALID)
    );

    assign RESCAN = rescan_q;
    assign SIGN   = sign_q;
    assign ACTIVE = act_q;

endmodule

// File: tb/tb_axis_dominance_compare.sv
// Randomised and directed bench for axis_dominance_compare against a behavioural model.
// Model works on plain integers: abs value, argmax with dead-band, counter-based hysteresis.
module tb_axis_dominance_compare;

    localparam int WIDTH    = 8;
    localparam int NAXES    = 3;
    localparam int DEADBAND = 4;
    localparam int HYST     = 3;

    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        TIC = 1'b0;
    logic        COMPLETED = 1'b0;
    logic [23:0] AXES = '0;
    logic        RESCAN;
    logic [2:0]  SIGN;
    logic [2:0]  ACTIVE;
    logic [1:0]  DOMINANT;
    logic        DOM_VALID;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: -1 stands for "no axis".
    int         m_cur  = -1;
    int         m_cand = -1;
    int         m_cnt  = 0;
    logic [2:0] m_sign = '0;
    logic [2:0] m_act  = '0;
    int         rv[3];

    axis_dominance_compare #(
        .WIDTH      (WIDTH),
        .NAXES      (NAXES),
        .DEADBAND   (DEADBAND),
        .HYST_COUNT (HYST)
    ) dut (
        .MCLK      (MCLK),
        .RST       (RST),
        .TIC       (TIC),
        .COMPLETED (COMPLETED),
        .AXES      (AXES),
        .RESCAN    (RESCAN),
        .SIGN      (SIGN),
        .ACTIVE    (ACTIVE),
        .DOMINANT  (DOMINANT),
        .DOM_VALID (DOM_VALID)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_sign"},   32'(SIGN),      32'(m_sign));
        chk({tag, "_active"}, 32'(ACTIVE),    32'(m_act));
        chk({tag, "_dom"},    32'(DOMINANT),  (m_cur < 0) ? 32'd0 : 32'(m_cur));
        chk({tag, "_domvld"}, 32'(DOM_VALID), (m_cur < 0) ? 32'd0 : 32'd1);
    endtask

    task automatic model_reset();
        m_cur  = -1;
        m_cand = -1;
        m_cnt  = 0;
        m_sign = '0;
        m_act  = '0;
    endtask

    task automatic model_commit(input int w);
        if (w == m_cur) begin
            m_cnt = 0;
        end else if (w == m_cand) begin
            m_cnt++;
            if (m_cnt == HYST) begin
                m_cur = m_cand;
                m_cnt = 0;
            end
        end else begin
            m_cand = w;
            m_cnt  = 1;
            if (HYST == 1) begin
                m_cur = w;
                m_cnt = 0;
            end
        end
    endtask

    task automatic model_sample(input int x, input int y, input int z);
        int v[3];
        int best;
        int bmag;
        int mg;
        v[0] = x; v[1] = y; v[2] = z;
        best = -1;
        bmag = 0;
        m_sign = '0;
        m_act  = '0;
        for (int i = 0; i < 3; i++) begin
            mg = (v[i] < 0) ? -v[i] : v[i];
            if (mg > DEADBAND) begin
                m_act[i]  = 1'b1;
                m_sign[i] = (v[i] > 0);
                if (mg > bmag) begin
                    bmag = mg;
                    best = i;
                end
            end
        end
        model_commit(best);
    endtask

    task automatic drive_axes(input int x, input int y, input int z);
        AXES[7:0]   = 8'(x);
        AXES[15:8]  = 8'(y);
        AXES[23:16] = 8'(z);
    endtask

    // One accepted sample; optional noise pulses TIC&&COMPLETED and scrambles AXES mid-scan.
    task automatic run_sample(input int x, input int y, input int z, input bit noise);
        int edges;
        model_sample(x, y, z);
        @(negedge MCLK);
        drive_axes(x, y, z);
        TIC = 1'b1;
        COMPLETED = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        if (noise) begin
            AXES = 24'($urandom);
        end else begin
            TIC = 1'b0;
            COMPLETED = 1'b0;
        end
        edges = 0;
        while (edges < 16) begin
            @(posedge MCLK);
            edges++;
            @(negedge MCLK);
            if (edges == 1) begin
                TIC = 1'b0;
                COMPLETED = 1'b0;
            end
            if (RESCAN) break;
        end
        chk("rescan_latency", 32'(edges), 32'd4);
        chk_outputs("commit");
        @(posedge MCLK);
        @(negedge MCLK);
        chk("rescan_width", 32'(RESCAN), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        bit t;
        for (int i = 0; i < n; i++) begin
            @(negedge MCLK);
            t = 1'($urandom_range(0, 1));
            TIC = t;
            COMPLETED = ~t;
            @(posedge MCLK);
            #1;
            chk("idle_no_rescan", 32'(RESCAN), 32'd0);
        end
        @(negedge MCLK);
        TIC = 1'b0;
        COMPLETED = 1'b0;
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 255)) - 128;
            1:       return int'($urandom_range(0, 12)) - 6;
            2:       return ($urandom_range(0, 1) != 0) ? 20 : -20;
            default: return -128;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        model_reset();
        chk("reset_rescan", 32'(RESCAN), 32'd0);
        chk_outputs("reset");
        RST = 1'b0;
        idle_cycles(8);
        chk_outputs("idle");

        // Most negative value plus small positive, three commits to validate axis 0.
        for (int k = 0; k < 3; k++) run_sample(-128, 5, 0, 1'b0);

        // Tie resolves to lowest index; new winner needs three consecutive commits.
        for (int k = 0; k < 3; k++) run_sample(20, -20, 20, 1'b0);
        for (int k = 0; k < 3; k++) run_sample(0, 0, 50, 1'b0);

        // Dead-band boundary, interrupted drop, then full drop of DOM_VALID.
        run_sample(4, -4, 0, 1'b0);
        run_sample(4, -4, 0, 1'b0);
        run_sample(0, 0, 50, 1'b0);
        for (int k = 0; k < 3; k++) run_sample(4, -4, 0, 1'b0);

        // Ignored strobes and mid-scan changes.
        idle_cycles(5);
        run_sample(-90, 30, 7, 1'b1);
        run_sample(-90, 30, 7, 1'b1);
        run_sample(-90, 30, 7, 1'b1);

        // Build a pending candidate, then reset in the middle of a scan.
        run_sample(0, 60, 0, 1'b0);
        run_sample(0, 60, 0, 1'b0);
        @(negedge MCLK);
        drive_axes(0, 60, 0);
        TIC = 1'b1;
        COMPLETED = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        TIC = 1'b0;
        COMPLETED = 1'b0;
        @(posedge MCLK);
        @(negedge MCLK);
        RST = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        model_reset();
        chk("rst_rescan", 32'(RESCAN), 32'd0);
        chk_outputs("rst_mid_scan");
        RST = 1'b0;
        idle_cycles(6);
        for (int k = 0; k < 3; k++) run_sample(0, 60, 0, 1'b0);

        // Randomised traffic; repeats make the hysteresis actually switch.
        for (int i = 0; i < 3; i++) rv[i] = rnd_val();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 3; i++) rv[i] = rnd_val();
            end
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 4)));
            run_sample(rv[0], rv[1], rv[2], $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
